// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one full-subtractor step per clock.
// Optional signed-overflow output o_ovf is built only when OVERFLOW_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a_in,
  input  logic [WIDTH-1:0] i_b_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
`ifdef OVERFLOW_EN
  output logic             o_ovf,
`endif
  output logic             o_borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_bw;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d;
  logic             w_bw_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  assign w_a_bit    = r_a[0];
  assign w_b_bit    = r_b[0];
  assign w_d        = w_a_bit ^ w_b_bit ^ r_bw;
  assign w_bw_next  = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_bw);
  assign w_last     = (r_cnt == LAST_BIT);
  assign w_res_next = {w_d, r_res};

  assign o_busy       = (r_state == S_RUN);
  assign o_done       = (r_state == S_DONE);
  assign o_diff       = r_diff;
  assign o_borrow_out = r_borrow;

`ifdef OVERFLOW_EN
  logic r_ovf;
  assign o_ovf = r_ovf;

  // On the last step the operand LSBs are the original sign bits and w_d is the result sign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_ovf <= (w_a_bit != w_b_bit) & (w_d != w_a_bit);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_bw     <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_a_in;
            r_b     <= i_b_in;
            r_bw    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next[WIDTH-1:1];
          r_bw  <= w_bw_next;
          // Counter parks at its terminal value; the next accepted start clears it.
          if (w_last) begin
            r_diff   <= w_res_next;
            r_borrow <= w_bw_next;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: per-cycle comparison of an 8-bit instance against a transaction-level
// model, directed literal cases, and an exhaustive sweep of a 2-bit instance. OVERFLOW_EN adds ovf cases.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic         s8 = 1'b0;
  logic [W-1:0] a8 = '0;
  logic [W-1:0] b8 = '0;
  logic         busy8, done8, bw8;
  logic [W-1:0] d8;

  logic       s2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       busy2, done2, bw2;
  logic [1:0] d2;

`ifdef OVERFLOW_EN
  logic ovf8, ovf2;
`endif

  serial_subtractor #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .i_start(s8), .i_a_in(a8), .i_b_in(b8),
    .o_busy(busy8), .o_done(done8), .o_diff(d8),
`ifdef OVERFLOW_EN
    .o_ovf(ovf8),
`endif
    .o_borrow_out(bw8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .i_start(s2), .i_a_in(a2), .i_b_in(b2),
    .o_busy(busy2), .o_done(done2), .o_diff(d2),
`ifdef OVERFLOW_EN
    .o_ovf(ovf2),
`endif
    .o_borrow_out(bw2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level model: phase 0 idle, 1..W computing, W+1 result pulse.
  int           ph = 0;
  logic [W-1:0] ea = '0, eb = '0;
  logic [W-1:0] exp_diff = '0;
  logic         exp_bw = 1'b0;
  logic         exp_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; exp_diff = '0; exp_bw = 1'b0; exp_ovf = 1'b0;
    end else if (ph == 0) begin
      if (s8) begin ea = a8; eb = b8; ph = 1; end
    end else if (ph <= W) begin
      ph++;
      if (ph == W + 1) begin
        int sd;
        exp_diff = ea - eb;
        exp_bw   = (ea < eb);
        sd       = int'($signed(ea)) - int'($signed(eb));
        exp_ovf  = (sd > 127) || (sd < -128);
      end
    end else begin
      ph = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy8, (ph >= 1 && ph <= W));
      chk("done", done8, (ph == W + 1));
      chk("diff", d8, exp_diff);
      chk("borrow_out", bw8, exp_bw);
      chk("busy_done_excl", busy8 & done8, 1'b0);
`ifdef OVERFLOW_EN
      chk("ovf", ovf8, exp_ovf);
`endif
    end
  end

  // Pulse start for one accepted edge, then wait (bounded) for the done pulse.
  task automatic op8(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(posedge clk); #1 s8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1 s8 = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      if (done8) break;
      lat++;
    end
    $display("op8 a=%02h b=%02h -> diff=%02h borrow=%0b busy_cycles=%0d", a, b, d8, bw8, lat);
  endtask

  initial begin
    int lat;
    int seen;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_diff", d8, 8'h00);
    chk("rst_borrow", bw8, 1'b0);
    chk_en = 1'b1;
    rst = 1'b0;

    op8(8'h05, 8'h03, lat);
    chk("lat_05_03", lat, 8);
    chk("diff_05_03", d8, 8'h02);
    chk("bw_05_03", bw8, 1'b0);
    op8(8'h03, 8'h05, lat);
    chk("diff_03_05", d8, 8'hFE);
    chk("bw_03_05", bw8, 1'b1);
    op8(8'h00, 8'h00, lat);
    chk("diff_00_00", d8, 8'h00);
    chk("bw_00_00", bw8, 1'b0);

    // start held high with operands changing mid-computation
    @(posedge clk); #1 s8 = 1'b1; a8 = 8'hA5; b8 = 8'h3C;
    @(posedge clk); #1 a8 = W'($urandom); b8 = W'($urandom);
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      if (done8) break;
      lat++;
      a8 = W'($urandom); b8 = W'($urandom);
    end
    s8 = 1'b0;
    $display("hold-start a=A5 b=3C -> diff=%02h borrow=%0b busy_cycles=%0d", d8, bw8, lat);
    chk("lat_hold", lat, 8);
    chk("diff_A5_3C", d8, 8'h69);
    chk("bw_A5_3C", bw8, 1'b0);
    @(negedge clk);
    chk("no_restart", busy8, 1'b0);

    // reset in the middle of a computation
    @(posedge clk); #1 s8 = 1'b1; a8 = 8'h5A; b8 = 8'h11;
    @(posedge clk); #1 s8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", busy8, 1'b0);
    chk("midrst_diff", d8, 8'h00);
    chk("midrst_done", done8, 1'b0);
    $display("reset mid-run -> busy=%0b diff=%02h", busy8, d8);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen++;
    end
    chk("no_done_after_rst", seen, 0);
    op8(8'hFF, 8'h01, lat);
    chk("diff_FF_01", d8, 8'hFE);
    chk("bw_FF_01", bw8, 1'b0);

`ifdef OVERFLOW_EN
    op8(8'h80, 8'h01, lat);
    chk("diff_80_01", d8, 8'h7F);
    chk("ovf_80_01", ovf8, 1'b1);
    chk("bw_80_01", bw8, 1'b0);
    op8(8'h7F, 8'h01, lat);
    chk("diff_7F_01", d8, 8'h7E);
    chk("ovf_7F_01", ovf8, 1'b0);
`endif

    // random traffic, including starts while busy
    seen = 0;
    repeat (800) begin
      @(posedge clk); #1;
      s8 = ($urandom_range(0, 2) == 0);
      a8 = W'($urandom);
      b8 = W'($urandom);
      if (done8) seen++;
    end
    s8 = 1'b0;
    repeat (12) @(posedge clk);
    $display("random phase: %0d results observed", seen);
    chk("random_progress", (seen > 20), 1'b1);

    // WIDTH=2 exhaustive
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        int edges;
        logic [1:0] ed;
        @(posedge clk); #1 s2 = 1'b1; a2 = 2'(ia); b2 = 2'(ib);
        @(posedge clk); #1 s2 = 1'b0;
        edges = 1;
        while (edges < 10) begin
          @(posedge clk);
          edges++;
          #1;
          if (done2) break;
        end
        ed = 2'((ia - ib) & 3);
        $display("w2 a=%0d b=%0d -> diff=%0d borrow=%0b edges=%0d", ia, ib, d2, bw2, edges);
        chk("w2_edges", edges, 3);
        chk("w2_diff", d2, ed);
        chk("w2_borrow", bw2, (ia < ib));
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
